// File: rtl/mem_stage_access.sv
// rtl/mem_stage_access.sv - MEM pipeline stage: data-memory req/ack access, load align/extend, MEM/WB register
module mem_stage_access #(
   parameter int DATA_W = 64
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_memRead,
   input  logic              i_memWrite,
   input  logic              i_memToReg,
   input  logic              i_regWrite,
   input  logic [DATA_W-1:0] i_alu_out,
   input  logic [DATA_W-1:0] i_rs2_data,
   input  logic [4:0]        i_rd_addr,
   input  logic [31:0]       i_inst,
   output logic              o_stall,
   output logic              o_dmem_req,
   output logic              o_dmem_we,
   output logic [DATA_W-1:0] o_dmem_addr,
   output logic [DATA_W-1:0] o_dmem_wdata,
   output logic [7:0]        o_dmem_wstrb,
   input  logic              i_dmem_ack,
   input  logic [DATA_W-1:0] i_dmem_rdata,
   output logic              o_regWrite,
   output logic              o_memToReg,
   output logic [4:0]        o_rd_addr,
   output logic [DATA_W-1:0] o_alu_out,
   output logic [DATA_W-1:0] o_mem_data,
   output logic [31:0]       o_inst,
   output logic              o_mem_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q;
   logic              req_q;
   logic              we_q;
   logic [DATA_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [7:0]        wstrb_q;
   logic [2:0]        funct3_q;
   logic [2:0]        offset_q;
   logic [DATA_W-1:0] load_data_q;

   logic              wb_regWrite_q;
   logic              wb_memToReg_q;
   logic [4:0]        wb_rd_q;
   logic [DATA_W-1:0] wb_alu_q;
   logic [DATA_W-1:0] wb_mem_data_q;
   logic [31:0]       wb_inst_q;
   logic              wb_err_q;

   logic              wb_regWrite_d;
   logic              wb_memToReg_d;
   logic [4:0]        wb_rd_d;
   logic [DATA_W-1:0] wb_alu_d;
   logic [DATA_W-1:0] wb_mem_data_d;
   logic [31:0]       wb_inst_d;
   logic              wb_err_d;

   logic [2:0]        funct3;
   logic [2:0]        offset;
   logic              mem_op;
   logic              misaligned;
   logic              bad;
   logic              start;
   logic [7:0]        size_mask;
   logic [7:0]        wstrb_d;
   logic [DATA_W-1:0] wdata_d;
   logic [DATA_W-1:0] rdata_shifted;
   logic [DATA_W-1:0] load_ext_d;

   assign funct3 = i_inst[14:12];
   assign offset = i_alu_out[2:0];
   assign mem_op = i_memRead | i_memWrite;

   // Natural alignment check for the access size encoded in funct3[1:0]
   always_comb begin
      misaligned = 1'b0;
      size_mask  = 8'h00;
      case (funct3[1:0])
         2'b00: begin misaligned = 1'b0;             size_mask = 8'h01; end
         2'b01: begin misaligned = offset[0];        size_mask = 8'h03; end
         2'b10: begin misaligned = |offset[1:0];     size_mask = 8'h0F; end
         default: begin misaligned = |offset[2:0];   size_mask = 8'hFF; end
      endcase
   end

   // Illegal accesses are dropped without touching memory; only memory ops can be bad
   assign bad = mem_op & ((i_memRead & i_memWrite) | (funct3 == 3'b111) |
                          (i_memWrite & funct3[2]) | misaligned);

   assign start = (state_q == S_IDLE) & mem_op & ~bad;

   // Stall is released while reset is asserted so the front of the pipe is never held by a dead transaction
   assign o_stall = i_rst_n & (start | (state_q == S_BUSY));

   assign wstrb_d = i_memWrite ? (size_mask << offset) : 8'h00;
   assign wdata_d = i_rs2_data << {offset, 3'b000};

   assign rdata_shifted = i_dmem_rdata >> {offset_q, 3'b000};

   // Sign/zero extension of the lane-aligned read data; stores return zero
   always_comb begin
      load_ext_d = '0;
      if (!we_q) begin
         case (funct3_q)
            3'b000: load_ext_d = {{56{rdata_shifted[7]}},  rdata_shifted[7:0]};
            3'b001: load_ext_d = {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b010: load_ext_d = {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
            3'b011: load_ext_d = rdata_shifted;
            3'b100: load_ext_d = {56'd0, rdata_shifted[7:0]};
            3'b101: load_ext_d = {48'd0, rdata_shifted[15:0]};
            3'b110: load_ext_d = {32'd0, rdata_shifted[31:0]};
            default: load_ext_d = '0;
         endcase
      end
   end

   // Access FSM with registered memory-side outputs; ack is only honoured in BUSY
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= 8'h00;
         funct3_q    <= 3'b000;
         offset_q    <= 3'b000;
         load_data_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q  <= S_BUSY;
                  req_q    <= 1'b1;
                  we_q     <= i_memWrite;
                  addr_q   <= {i_alu_out[DATA_W-1:3], 3'b000};
                  wdata_q  <= wdata_d;
                  wstrb_q  <= wstrb_d;
                  funct3_q <= funct3;
                  offset_q <= offset;
               end
            end
            S_BUSY: begin
               if (i_dmem_ack) begin
                  state_q     <= S_DONE;
                  req_q       <= 1'b0;
                  we_q        <= 1'b0;
                  wstrb_q     <= 8'h00;
                  load_data_q <= load_ext_d;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
               we_q    <= 1'b0;
               wstrb_q <= 8'h00;
            end
         endcase
      end
   end

   // Next MEM/WB contents: bubble while stalled, otherwise the instruction leaving MEM
   always_comb begin
      wb_regWrite_d = 1'b0;
      wb_memToReg_d = 1'b0;
      wb_rd_d       = 5'd0;
      wb_alu_d      = '0;
      wb_mem_data_d = '0;
      wb_inst_d     = 32'd0;
      wb_err_d      = 1'b0;
      if (!o_stall) begin
         wb_regWrite_d = i_regWrite & ~bad;
         wb_memToReg_d = i_memToReg;
         wb_rd_d       = i_rd_addr;
         wb_alu_d      = i_alu_out;
         wb_mem_data_d = (state_q == S_DONE) ? load_data_q : '0;
         wb_inst_d     = i_inst;
         wb_err_d      = bad;
      end
   end

   // MEM/WB pipeline register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wb_regWrite_q <= 1'b0;
         wb_memToReg_q <= 1'b0;
         wb_rd_q       <= 5'd0;
         wb_alu_q      <= '0;
         wb_mem_data_q <= '0;
         wb_inst_q     <= 32'd0;
         wb_err_q      <= 1'b0;
      end else begin
         wb_regWrite_q <= wb_regWrite_d;
         wb_memToReg_q <= wb_memToReg_d;
         wb_rd_q       <= wb_rd_d;
         wb_alu_q      <= wb_alu_d;
         wb_mem_data_q <= wb_mem_data_d;
         wb_inst_q     <= wb_inst_d;
         wb_err_q      <= wb_err_d;
      end
   end

   assign o_dmem_req   = req_q;
   assign o_dmem_we    = we_q;
   assign o_dmem_addr  = addr_q;
   assign o_dmem_wdata = wdata_q;
   assign o_dmem_wstrb = wstrb_q;

   assign o_regWrite = wb_regWrite_q;
   assign o_memToReg = wb_memToReg_q;
   assign o_rd_addr  = wb_rd_q;
   assign o_alu_out  = wb_alu_q;
   assign o_mem_data = wb_mem_data_q;
   assign o_inst     = wb_inst_q;
   assign o_mem_err  = wb_err_q;

endmodule
